// File: rtl/vec_pack_pkg.sv
// Shared definitions for the vector field packer.
//   state_e   : packer FSM states (ST_RUN accepts fields, ST_FLUSH emits the
//               residual of an overflowing flush)
//   clog2     : elaboration-time ceiling log2, used for derived widths
//   clamp_len : limits a requested field length to the maximum field width
package vec_pack_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/vector_field_packer_if.sv
// Field-in / word-out handshake bundle for vector_field_packer.
//   in_valid/in_ready/in_data/in_len/in_flush : field stream into the packer
//   out_valid/out_ready/out_data/out_count    : packed word stream out
// Modports: slave = packer side, master = producer/consumer side.
interface vector_field_packer_if
  import vec_pack_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) ();
  localparam int LEN_W = clog2(IN_W + 1);
  localparam int CNT_W = clog2(OUT_W + 1);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [LEN_W-1:0] in_len;
  logic             in_flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_data, in_len, in_flush, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

  modport master (
    output in_valid, in_data, in_len, in_flush, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/vec_pack_outreg.sv
// Single-entry valid/ready holding register for packed output words.
//   load/load_data/load_count : write a new word (caller only loads when the
//                               slot is empty or draining this cycle)
//   out_valid/out_ready       : downstream handshake
//   out_data/out_count        : held word, stable until consumed
module vec_pack_outreg #(
  parameter int OUT_W = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [OUT_W-1:0] load_data,
  input  logic [CNT_W-1:0] load_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count
);
  logic             valid_reg;
  logic [OUT_W-1:0] data_reg;
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      count_reg <= '0;
    end else if (load) begin
      // A load on the draining edge replaces the old word with no bubble.
      valid_reg <= 1'b1;
      data_reg  <= load_data;
      count_reg <= load_count;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_count = count_reg;
endmodule

// File: rtl/vector_field_packer.sv
// Packs variable-width fields MSB-first into OUT_W-bit words.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave side of vector_field_packer_if (fields in, words out)
// Held bits sit right-justified in acc_reg; each accepted field is shifted
// in below them. A flush that overflows one word parks the leftover bits and
// emits them from ST_FLUSH once the output slot frees up.
module vector_field_packer
  import vec_pack_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  vector_field_packer_if.slave  bus
);
  localparam int LEN_W = clog2(IN_W + 1);
  localparam int CNT_W = clog2(OUT_W + 1);
  localparam int ACC_W = OUT_W + IN_W;
  localparam int SUM_W = clog2(OUT_W + IN_W + 1);
  localparam logic [SUM_W-1:0] OUT_W_S = SUM_W'(OUT_W);

  state_e           state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] fill_reg;

  logic             out_valid;
  logic             slot_free;
  logic             accept;
  logic [LEN_W-1:0] len_c;
  logic [SUM_W-1:0] total;
  logic [SUM_W-1:0] excess;
  logic             over;
  logic [ACC_W-1:0] field;
  logic [ACC_W-1:0] combined;
  logic [ACC_W-1:0] resid_acc;
  logic [OUT_W-1:0] full_word;
  logic [OUT_W-1:0] pad_word;
  logic [OUT_W-1:0] resid_word;

  logic             load;
  logic [OUT_W-1:0] load_data;
  logic [CNT_W-1:0] load_count;

  assign slot_free    = ~out_valid | bus.out_ready;
  assign bus.in_ready = ~rst & (state_reg == ST_RUN) & slot_free;
  assign accept       = bus.in_valid & bus.in_ready;

  assign len_c  = LEN_W'(clamp_len(32'(bus.in_len), IN_W));
  assign total  = SUM_W'(fill_reg) + SUM_W'(len_c);
  assign excess = total - OUT_W_S;
  assign over   = (total >= OUT_W_S);

  // Mask off in_data bits above the field length before appending.
  assign field     = ACC_W'(bus.in_data) & ~({ACC_W{1'b1}} << len_c);
  assign combined  = (acc_reg << len_c) | field;
  // Top OUT_W of the total bits form the full word; the rest stay held.
  assign full_word = OUT_W'(combined >> excess);
  assign resid_acc = combined & ~({ACC_W{1'b1}} << excess);
  // Partial words are left-justified with zeros below.
  assign pad_word   = OUT_W'(combined << (OUT_W_S - total));
  assign resid_word = OUT_W'(acc_reg << (OUT_W_S - SUM_W'(fill_reg)));

  always_comb begin
    load       = 1'b0;
    load_data  = '0;
    load_count = '0;
    if (state_reg == ST_FLUSH) begin
      if (slot_free) begin
        load       = 1'b1;
        load_data  = resid_word;
        load_count = fill_reg;
      end
    end else if (accept) begin
      if (over) begin
        load       = 1'b1;
        load_data  = full_word;
        load_count = CNT_W'(OUT_W);
      end else if (bus.in_flush && (total != '0)) begin
        load       = 1'b1;
        load_data  = pad_word;
        load_count = CNT_W'(total);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      acc_reg   <= '0;
      fill_reg  <= '0;
    end else if (state_reg == ST_FLUSH) begin
      if (slot_free) begin
        acc_reg   <= '0;
        fill_reg  <= '0;
        state_reg <= ST_RUN;
      end
    end else if (accept) begin
      if (over) begin
        acc_reg  <= resid_acc;
        fill_reg <= CNT_W'(excess);
        // Leftover bits of a flush need a second word slot.
        if (bus.in_flush && (excess != '0)) state_reg <= ST_FLUSH;
      end else if (bus.in_flush) begin
        acc_reg  <= '0;
        fill_reg <= '0;
      end else begin
        acc_reg  <= combined;
        fill_reg <= CNT_W'(total);
      end
    end
  end

  vec_pack_outreg #(
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) u_outreg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (load_data),
    .load_count (load_count),
    .out_valid  (out_valid),
    .out_ready  (bus.out_ready),
    .out_data   (bus.out_data),
    .out_count  (bus.out_count)
  );

  assign bus.out_valid = out_valid;
endmodule
